// File: rtl/mem_access_stage_if.sv
// Execute / data-memory / writeback signal bundle for mem_access_stage.
// The slave modport is the stage's view; the master modport is the surrounding pipeline's view.
interface mem_access_stage_if #(
    parameter int LANES  = 8,
    parameter int LANE_W = 24,
    parameter int ADDR_W = 10,
    parameter int SCAL_W = 21,
    parameter int EXC_W  = 5,
    parameter int RD_W   = 4
);
    logic                    ex_valid;
    logic                    ex_ready;
    logic [EXC_W-1:0]        ex_exc;
    logic [SCAL_W-1:0]       ex_res_e;
    logic [LANES*LANE_W-1:0] ex_res_v;
    logic [SCAL_W-1:0]       ex_st_e;
    logic [RD_W-1:0]         ex_rd;
    logic                    ex_we;

    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_re;
    logic                    mem_we;
    logic [LANE_W-1:0]       mem_wdata;
    logic [LANE_W-1:0]       mem_rdata;

    logic                    wb_valid;
    logic [EXC_W-1:0]        wb_exc;
    logic [RD_W-1:0]         wb_rd;
    logic                    wb_we;
    logic [SCAL_W-1:0]       wb_res_e;
    logic [LANES*LANE_W-1:0] wb_res_v;
    logic                    wb_fault;

    modport master (
        output ex_valid, ex_exc, ex_res_e, ex_res_v, ex_st_e, ex_rd, ex_we, mem_rdata,
        input  ex_ready, mem_addr, mem_re, mem_we, mem_wdata,
        input  wb_valid, wb_exc, wb_rd, wb_we, wb_res_e, wb_res_v, wb_fault
    );

    modport slave (
        input  ex_valid, ex_exc, ex_res_e, ex_res_v, ex_st_e, ex_rd, ex_we, mem_rdata,
        output ex_ready, mem_addr, mem_re, mem_we, mem_wdata,
        output wb_valid, wb_exc, wb_rd, wb_we, wb_res_e, wb_res_v, wb_fault
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: scalar/vector loads and stores over a lane-wide synchronous memory.
// Optional macro MEM_ALIGN_CHK_EN: fault vector accesses whose base is not a multiple of LANES.
module mem_access_stage #(
    parameter int LANES  = 8,
    parameter int LANE_W = 24,
    parameter int ADDR_W = 10,
    parameter int SCAL_W = 21,
    parameter int EXC_W  = 5,
    parameter int RD_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_stage_if.slave  bus
);
    localparam int BEAT_W = $clog2(LANES);
    localparam logic [EXC_W-1:0] OP_VLD = 5'b11100;
    localparam logic [EXC_W-1:0] OP_VST = 5'b11101;
    localparam logic [EXC_W-1:0] OP_SLD = 5'b11110;
    localparam logic [EXC_W-1:0] OP_SST = 5'b11111;

    typedef enum logic [2:0] {S_IDLE, S_SLD, S_SLD_W, S_SST, S_VLD, S_VLD_T, S_VST} state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [SCAL_W-1:0]       st_q, st_d;
    logic                    cap_q, cap_d;
    logic [BEAT_W-1:0]       cap_lane_q, cap_lane_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [EXC_W-1:0]        wb_exc_q, wb_exc_d;
    logic [RD_W-1:0]         wb_rd_q, wb_rd_d;
    logic                    wb_we_q, wb_we_d;
    logic [SCAL_W-1:0]       wb_res_e_q, wb_res_e_d;
    logic [LANES*LANE_W-1:0] wb_res_v_q, wb_res_v_d;
`ifdef MEM_ALIGN_CHK_EN
    logic                    wb_fault_q, wb_fault_d;
`endif

    logic                    ex_ready_c, mem_re_c, mem_we_c;
    logic [ADDR_W-1:0]       mem_addr_c;
    logic [LANE_W-1:0]       mem_wdata_c;
    logic [LANE_W-1:0]       st_lane [LANES];

    // Vector store data is read back from the latched result vector, one lane per beat.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign st_lane[gi] = wb_res_v_q[gi*LANE_W +: LANE_W];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        st_d        = st_q;
        cap_d       = 1'b0;
        cap_lane_d  = cap_lane_q;
        wb_valid_d  = 1'b0;
        wb_exc_d    = wb_exc_q;
        wb_rd_d     = wb_rd_q;
        wb_we_d     = wb_we_q;
        wb_res_e_d  = wb_res_e_q;
        wb_res_v_d  = wb_res_v_q;
`ifdef MEM_ALIGN_CHK_EN
        wb_fault_d  = wb_fault_q;
`endif
        mem_re_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        ex_ready_c  = !rst && (state_q == S_IDLE);

        // Read data for the beat issued last cycle lands in its lane now.
        if (cap_q)
            wb_res_v_d[cap_lane_q*LANE_W +: LANE_W] = bus.mem_rdata;

        case (state_q)
            S_IDLE: begin
                if (bus.ex_valid && ex_ready_c) begin
                    wb_exc_d   = bus.ex_exc;
                    wb_rd_d    = bus.ex_rd;
                    wb_we_d    = bus.ex_we;
                    wb_res_e_d = bus.ex_res_e;
                    wb_res_v_d = bus.ex_res_v;
                    addr_d     = bus.ex_res_e[ADDR_W-1:0];
                    st_d       = bus.ex_st_e;
                    beat_d     = '0;
`ifdef MEM_ALIGN_CHK_EN
                    wb_fault_d = 1'b0;
`endif
                    case (bus.ex_exc)
                        OP_VLD, OP_VST: begin
                            state_d = (bus.ex_exc == OP_VLD) ? S_VLD : S_VST;
                            if (bus.ex_exc == OP_VST)
                                wb_we_d = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
                            if (bus.ex_res_e[BEAT_W-1:0] != '0) begin
                                state_d    = S_IDLE;
                                wb_valid_d = 1'b1;
                                wb_fault_d = 1'b1;
                                wb_we_d    = 1'b0;
                            end
`endif
                        end
                        OP_SLD:  state_d = S_SLD;
                        OP_SST: begin
                            state_d = S_SST;
                            wb_we_d = 1'b0;
                        end
                        default: wb_valid_d = 1'b1;
                    endcase
                end
            end
            S_SLD: begin
                mem_re_c   = 1'b1;
                mem_addr_c = addr_q;
                state_d    = S_SLD_W;
            end
            S_SLD_W: begin
                wb_res_e_d = bus.mem_rdata[SCAL_W-1:0];
                wb_valid_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_SST: begin
                mem_we_c    = 1'b1;
                mem_addr_c  = addr_q;
                mem_wdata_c = LANE_W'(st_q);
                wb_valid_d  = 1'b1;
                state_d     = S_IDLE;
            end
            S_VLD: begin
                mem_re_c   = 1'b1;
                mem_addr_c = addr_q + ADDR_W'(beat_q);
                cap_d      = 1'b1;
                cap_lane_d = beat_q;
                beat_d     = beat_q + 1'b1;
                if (beat_q == BEAT_W'(LANES-1)) begin
                    beat_d  = '0;
                    state_d = S_VLD_T;
                end
            end
            S_VLD_T: begin
                wb_valid_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_VST: begin
                mem_we_c    = 1'b1;
                mem_addr_c  = addr_q + ADDR_W'(beat_q);
                mem_wdata_c = st_lane[beat_q];
                beat_d      = beat_q + 1'b1;
                if (beat_q == BEAT_W'(LANES-1)) begin
                    beat_d     = '0;
                    wb_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            addr_q     <= '0;
            st_q       <= '0;
            cap_q      <= 1'b0;
            cap_lane_q <= '0;
            wb_valid_q <= 1'b0;
            wb_exc_q   <= '0;
            wb_rd_q    <= '0;
            wb_we_q    <= 1'b0;
            wb_res_e_q <= '0;
            wb_res_v_q <= '0;
`ifdef MEM_ALIGN_CHK_EN
            wb_fault_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            st_q       <= st_d;
            cap_q      <= cap_d;
            cap_lane_q <= cap_lane_d;
            wb_valid_q <= wb_valid_d;
            wb_exc_q   <= wb_exc_d;
            wb_rd_q    <= wb_rd_d;
            wb_we_q    <= wb_we_d;
            wb_res_e_q <= wb_res_e_d;
            wb_res_v_q <= wb_res_v_d;
`ifdef MEM_ALIGN_CHK_EN
            wb_fault_q <= wb_fault_d;
`endif
        end
    end

    assign bus.ex_ready  = ex_ready_c;
    assign bus.mem_re    = mem_re_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_exc    = wb_exc_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_we     = wb_we_q;
    assign bus.wb_res_e  = wb_res_e_q;
    assign bus.wb_res_v  = wb_res_v_q;
`ifdef MEM_ALIGN_CHK_EN
    assign bus.wb_fault  = wb_fault_q;
`else
    assign bus.wb_fault  = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with a behavioural synchronous-read data memory.
// Honours MEM_ALIGN_CHK_EN the same way the design does.
module tb_mem_access_stage;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    mem_access_stage_if #(.LANES(8), .LANE_W(24), .ADDR_W(10), .SCAL_W(21), .EXC_W(5), .RD_W(4)) bus ();

    mem_access_stage #(.LANES(8), .LANE_W(24), .ADDR_W(10), .SCAL_W(21), .EXC_W(5), .RD_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [23:0] dmem [1024];
    always @(posedge clk) begin
        if (bus.mem_we) dmem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= dmem[bus.mem_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues a vector load at base and checks every cycle through retirement.
    task automatic run_vload(input logic [9:0] base, input logic chk_data, input logic [191:0] exp_v);
        logic [9:0] a;
        bus.ex_valid = 1'b1;
        bus.ex_exc   = 5'b11100;
        bus.ex_res_e = 21'(base);
        bus.ex_res_v = {8{24'hAAAAAA}};
        bus.ex_rd    = 4'd5;
        bus.ex_we    = 1'b1;
        chk("vld_ready_t0", bus.ex_ready, 1'b1);
        tick();
        bus.ex_valid = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
        if (base[2:0] != 3'd0) begin
            chk("vld_fault_valid", bus.wb_valid, 1'b1);
            chk("vld_fault_flag", bus.wb_fault, 1'b1);
            chk("vld_fault_we", bus.wb_we, 1'b0);
            chk("vld_fault_no_re", bus.mem_re, 1'b0);
            tick();
            chk("vld_fault_ready_after", bus.ex_ready, 1'b1);
            chk("vld_fault_pulse_end", bus.wb_valid, 1'b0);
            return;
        end
`endif
        for (int k = 0; k < 8; k++) begin
            a = base + 10'(k);
            chk($sformatf("vld_re_b%0d", k), bus.mem_re, 1'b1);
            chk($sformatf("vld_we_b%0d", k), bus.mem_we, 1'b0);
            chk($sformatf("vld_addr_b%0d", k), bus.mem_addr, a);
            chk($sformatf("vld_ready_b%0d", k), bus.ex_ready, 1'b0);
            chk($sformatf("vld_wbv_b%0d", k), bus.wb_valid, 1'b0);
            tick();
        end
        chk("vld_t9_re", bus.mem_re, 1'b0);
        chk("vld_t9_ready", bus.ex_ready, 1'b0);
        chk("vld_t9_wbv", bus.wb_valid, 1'b0);
        tick();
        chk("vld_t10_wbv", bus.wb_valid, 1'b1);
        chk("vld_t10_we", bus.wb_we, 1'b1);
        chk("vld_t10_rd", bus.wb_rd, 4'd5);
        chk("vld_t10_res_e", bus.wb_res_e, 21'(base));
        chk("vld_t10_fault", bus.wb_fault, 1'b0);
        chk("vld_t10_ready", bus.ex_ready, 1'b1);
        if (chk_data) chk("vld_t10_res_v", bus.wb_res_v, exp_v);
        tick();
        chk("vld_pulse_end", bus.wb_valid, 1'b0);
    endtask

    initial begin
        logic [191:0] vec;
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.ex_valid = 1'b0;
        bus.ex_exc   = '0;
        bus.ex_res_e = '0;
        bus.ex_res_v = '0;
        bus.ex_st_e  = '0;
        bus.ex_rd    = '0;
        bus.ex_we    = 1'b0;
        for (int k = 0; k < 8; k++) vec[k*24 +: 24] = 24'(k + 1);

        // Reset state
        tick();
        tick();
        chk("rst_ready", bus.ex_ready, 1'b0);
        chk("rst_wbv", bus.wb_valid, 1'b0);
        chk("rst_re", bus.mem_re, 1'b0);
        chk("rst_we", bus.mem_we, 1'b0);
        chk("rst_addr", bus.mem_addr, 10'd0);
        chk("rst_res_e", bus.wb_res_e, 21'd0);
        chk("rst_fault", bus.wb_fault, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.ex_ready, 1'b1);

        // Pass-through, back to back
        bus.ex_valid = 1'b1;
        bus.ex_exc   = 5'b01110;
        bus.ex_res_e = 21'd15;
        bus.ex_rd    = 4'd1;
        bus.ex_we    = 1'b1;
        tick();
        chk("pt1_wbv", bus.wb_valid, 1'b1);
        chk("pt1_res_e", bus.wb_res_e, 21'd15);
        chk("pt1_exc", bus.wb_exc, 5'b01110);
        chk("pt1_we", bus.wb_we, 1'b1);
        chk("pt1_ready", bus.ex_ready, 1'b1);
        bus.ex_exc   = 5'b00101;
        bus.ex_res_e = 21'd9;
        tick();
        chk("pt2_wbv", bus.wb_valid, 1'b1);
        chk("pt2_res_e", bus.wb_res_e, 21'd9);
        chk("pt2_exc", bus.wb_exc, 5'b00101);
        chk("pt2_ready", bus.ex_ready, 1'b1);
        bus.ex_valid = 1'b0;
        tick();
        chk("pt_idle_wbv", bus.wb_valid, 1'b0);

        // Scalar store to address 5
        bus.ex_valid = 1'b1;
        bus.ex_exc   = 5'b11111;
        bus.ex_res_e = 21'd5;
        bus.ex_st_e  = 21'h1ABCD;
        bus.ex_rd    = 4'd2;
        bus.ex_we    = 1'b1;
        tick();
        bus.ex_valid = 1'b0;
        chk("sst_we", bus.mem_we, 1'b1);
        chk("sst_re", bus.mem_re, 1'b0);
        chk("sst_addr", bus.mem_addr, 10'd5);
        chk("sst_wdata", bus.mem_wdata, 24'h01ABCD);
        chk("sst_ready", bus.ex_ready, 1'b0);
        chk("sst_t1_wbv", bus.wb_valid, 1'b0);
        tick();
        chk("sst_t2_wbv", bus.wb_valid, 1'b1);
        chk("sst_t2_we", bus.wb_we, 1'b0);
        chk("sst_t2_mem_we", bus.mem_we, 1'b0);
        chk("sst_t2_ready", bus.ex_ready, 1'b1);

        // Scalar load from address 5
        bus.ex_valid = 1'b1;
        bus.ex_exc   = 5'b11110;
        bus.ex_res_e = 21'd5;
        bus.ex_st_e  = 21'd0;
        bus.ex_rd    = 4'd3;
        bus.ex_we    = 1'b1;
        tick();
        bus.ex_valid = 1'b0;
        chk("sld_t1_re", bus.mem_re, 1'b1);
        chk("sld_t1_we", bus.mem_we, 1'b0);
        chk("sld_t1_addr", bus.mem_addr, 10'd5);
        chk("sld_t1_ready", bus.ex_ready, 1'b0);
        tick();
        chk("sld_t2_re", bus.mem_re, 1'b0);
        chk("sld_t2_ready", bus.ex_ready, 1'b0);
        chk("sld_t2_wbv", bus.wb_valid, 1'b0);
        tick();
        chk("sld_t3_wbv", bus.wb_valid, 1'b1);
        chk("sld_t3_res_e", bus.wb_res_e, 21'h1ABCD);
        chk("sld_t3_rd", bus.wb_rd, 4'd3);
        chk("sld_t3_we", bus.wb_we, 1'b1);
        chk("sld_t3_ready", bus.ex_ready, 1'b1);

        // Vector store lanes 1..8 at base 16
        bus.ex_valid = 1'b1;
        bus.ex_exc   = 5'b11101;
        bus.ex_res_e = 21'd16;
        bus.ex_res_v = vec;
        bus.ex_rd    = 4'd4;
        bus.ex_we    = 1'b1;
        tick();
        bus.ex_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("vst_we_b%0d", k), bus.mem_we, 1'b1);
            chk($sformatf("vst_re_b%0d", k), bus.mem_re, 1'b0);
            chk($sformatf("vst_addr_b%0d", k), bus.mem_addr, 10'(16 + k));
            chk($sformatf("vst_wdata_b%0d", k), bus.mem_wdata, 24'(k + 1));
            chk($sformatf("vst_ready_b%0d", k), bus.ex_ready, 1'b0);
            chk($sformatf("vst_wbv_b%0d", k), bus.wb_valid, 1'b0);
            tick();
        end
        chk("vst_t9_wbv", bus.wb_valid, 1'b1);
        chk("vst_t9_we", bus.wb_we, 1'b0);
        chk("vst_t9_mem_we", bus.mem_we, 1'b0);
        chk("vst_t9_ready", bus.ex_ready, 1'b1);

        // Vector load back from base 16
        run_vload(10'd16, 1'b1, vec);

        // Address wrap at the top of memory
        run_vload(10'd1020, 1'b0, '0);

        // Unaligned base
        run_vload(10'd3, 1'b0, '0);

        // Reset during beat 3 of a vector store
        bus.ex_valid = 1'b1;
        bus.ex_exc   = 5'b11101;
        bus.ex_res_e = 21'd32;
        bus.ex_res_v = vec;
        tick();
        bus.ex_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("rmid_b3_we", bus.mem_we, 1'b1);
        chk("rmid_b3_addr", bus.mem_addr, 10'd35);
        rst = 1'b1;
        tick();
        chk("rmid_we_after", bus.mem_we, 1'b0);
        chk("rmid_wbv_after", bus.wb_valid, 1'b0);
        chk("rmid_ready_in_rst", bus.ex_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("rmid_ready_post", bus.ex_ready, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("rmid_quiet_wbv_%0d", k), bus.wb_valid, 1'b0);
            chk($sformatf("rmid_quiet_we_%0d", k), bus.mem_we, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the execute results, the execute control code and the destination register, then performs data-memory accesses for loads and stores.
- Vector accesses are serialized as LANES beats over a lane-wide, synchronous-read data memory.
- Hands the final scalar and vector results to writeback with a one-cycle valid pulse, and stalls execute while a multi-beat access is in flight.

Parameters:
- LANES, 8: vector lanes; one memory beat per lane.
- LANE_W, 24: lane and memory word width; LANES*LANE_W = 192.
- ADDR_W, 10: data-memory word-address width.
- SCAL_W, 21: scalar datapath width.
- EXC_W, 5: execute control code width.
- RD_W, 4: destination register index width.

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: synchronous reset, active-high.
- ex_valid  in  1: execute has an instruction for this stage.
- ex_ready  out  1: stage can accept; high only in IDLE.
- ex_exc  in  EXC_W: control code.
- ex_res_e  in  SCAL_W: scalar result; low ADDR_W bits are the address for memory ops.
- ex_res_v  in  LANES*LANE_W: vector result; vector store data.
- ex_st_e  in  SCAL_W: scalar store data.
- ex_rd  in  RD_W: destination register index.
- ex_we  in  1: destination write enable.
- mem_addr  out  ADDR_W: memory word address.
- mem_re  out  1: read strobe; data returns on mem_rdata the following cycle.
- mem_we  out  1: write strobe.
- mem_wdata  out  LANE_W: write data.
- mem_rdata  in  LANE_W: read data.
- wb_valid  out  1: one-cycle retire pulse.
- wb_exc  out  EXC_W: retired control code.
- wb_rd  out  RD_W: retired destination index.
- wb_we  out  1: writeback enable.
- wb_res_e  out  SCAL_W: scalar result.
- wb_res_v  out  LANES*LANE_W: vector result.
- wb_fault  out  1: alignment fault; see Optional Feature.

Behaviour:
- Reset: all outputs 0 (ex_ready 0 during the reset cycle, 1 afterwards); state IDLE; beat counter 0. Reset mid-access aborts the access; mem_re/mem_we are low from the cycle after the reset edge; no wb_valid for the aborted instruction.
- Opcodes:
  - 11100 vector load
  - 11101 vector store
  - 11110 scalar load
  - 11111 scalar store
  - all other codes pass through.
- Accept: in cycle T0 when ex_valid && ex_ready. All ex_* inputs are latched. No back-pressure from writeback.
- Pass-through: state stays IDLE; in T1, wb_valid=1 and wb_* equal the latched ex_* values. Throughput is 1 per cycle.
- Scalar load: SLD in T1 with mem_re=1 and mem_addr=addr. In T2, SLD_W captures mem_rdata[SCAL_W-1:0] into wb_res_e. wb_valid in T3. ex_ready is low in T1–T2.
- Scalar store: SST in T1 with mem_we=1, mem_addr=addr, mem_wdata=zero-extended ex_st_e. wb_valid in T2 with wb_we=0.
- Vector load (VLD): in T1..T(LANES), mem_re=1 and mem_addr=base+k for beat k.
  - Beat k data is captured into lane k (bits [LANE_W*k+LANE_W-1 : LANE_W*k]) at the end of T(k+2).
  - VLD_T in T(LANES+1) captures the last beat.
  - wb_valid in T(LANES+2), i.e. T10 with defaults.
  - ex_ready is low from T1 through T(LANES+1).
- Vector store (VST): in T1..T(LANES), mem_we=1, mem_addr=base+k, mem_wdata=lane k of ex_res_v. wb_valid in T(LANES+1) with wb_we=0.
- Load results: wb_we equals the latched ex_we. wb_res_v is unchanged on scalar ops; wb_res_e is unchanged on vector loads.
- Address arithmetic: base+k is modulo 2^ADDR_W; the address wraps from 1023 to 0.
- mem_re and mem_we are never high together. Both are 0 in IDLE and in the SLD_W and VLD_T states.
- An ex_valid that arrives while ex_ready=0 is ignored; upstream holds it.
- wb_fault is 0 unless the optional feature is enabled.

Optional Feature:
- MEM_ALIGN_CHK_EN defined: a vector load or store whose base is not a multiple of LANES performs no memory access. It retires in T1 with wb_valid=1, wb_fault=1 and wb_we=0.
- MEM_ALIGN_CHK_EN undefined: unaligned bases are legal, wb_fault is tied to 0, and no check logic is present.

Test Plan:
- Pass-through, back-to-back: exc=01110, res_e=15, then exc=00101, res_e=9, on consecutive cycles -> wb_valid pulses on 2 consecutive cycles with wb_res_e=15, then 9; ex_ready stays 1.
- Scalar store/load: store st_e=0x1ABCD to addr 5, then load addr 5, rd=3 -> mem_we with wdata=0x01ABCD in T1; load gives wb_res_e=0x1ABCD, wb_rd=3, wb_valid at accept+3.
- Vector store/load: store lanes 0..7 = 0x000001..0x000008 at base 16, then load base 16 -> addresses 16..23 written; load gives wb_res_v equal to the stored vector; wb_valid at accept+10; ex_ready low for 9 cycles.
- Address wrap: vector load at base 1020 -> mem_addr sequence 1020, 1021, 1022, 1023, 0, 1, 2, 3.
- Reset mid-access: assert rst during beat 3 of a vector store -> mem_we=0 on the next cycle; no wb_valid; ex_ready=1 after rst deasserts.
- With MEM_ALIGN_CHK_EN: vector load at base 3 -> no mem_re; wb_valid=1 and wb_fault=1 at accept+1. Without the macro, the same stimulus performs 8 beats at addresses 3..10.
